// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        DRAIN    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        REDIRECT = 2'd3
    } pipe_state_e;

    // en/flush bit order: [0]=p1p2, [1]=p2p3, [2]=p3p4, [3]=p4p5
    typedef struct packed {
        logic       pc_en;
        logic [3:0] en;
        logic [3:0] flush;
    } pipe_strobe_t;

    localparam logic [31:0] NOP_INSN = 32'h00000013;

    localparam pipe_strobe_t STB_DRAIN    = '{pc_en: 1'b0, en: 4'b0000, flush: 4'b1111};
    localparam pipe_strobe_t STB_RUN      = '{pc_en: 1'b1, en: 4'b1111, flush: 4'b0000};
    localparam pipe_strobe_t STB_MEM_WAIT = '{pc_en: 1'b0, en: 4'b1000, flush: 4'b1000};
    localparam pipe_strobe_t STB_REDIRECT = '{pc_en: 1'b1, en: 4'b1111, flush: 4'b0011};
    localparam pipe_strobe_t STB_LOAD_USE = '{pc_en: 1'b0, en: 4'b1110, flush: 4'b0010};
    localparam pipe_strobe_t STB_FETCH_BUB = '{pc_en: 1'b0, en: 4'b1111, flush: 4'b0001};

endpackage

// File: rtl/pipe_load_use_det.sv
// rtl/pipe_load_use_det.sv - combinational load-use hazard detect between P2 sources and P3 load
module pipe_load_use_det (
    input  logic [4:0] i_p2_rs1_addr,
    input  logic [4:0] i_p2_rs2_addr,
    input  logic       i_p2_uses_rs1,
    input  logic       i_p2_uses_rs2,
    input  logic [4:0] i_p3_rd_addr,
    input  logic       i_p3_mem_read,
    output logic       o_load_use
);

    // x0 is never a real producer, so a load targeting it cannot create a hazard
    assign o_load_use = i_p3_mem_read && (i_p3_rd_addr != 5'd0) &&
                        ((i_p2_uses_rs1 && (i_p2_rs1_addr == i_p3_rd_addr)) ||
                         (i_p2_uses_rs2 && (i_p2_rs2_addr == i_p3_rd_addr)));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencing FSM: enables, flushes, hazards and stall counter
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RST_DRAIN_CYCLES = 2,
    parameter int REDIRECT_SHADOW  = 1,
    parameter int STALL_CNT_W      = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_p1_insn_valid,
    input  logic [4:0]             i_p2_rs1_addr,
    input  logic [4:0]             i_p2_rs2_addr,
    input  logic                   i_p2_uses_rs1,
    input  logic                   i_p2_uses_rs2,
    input  logic [4:0]             i_p3_rd_addr,
    input  logic                   i_p3_mem_read,
    input  logic                   i_p3_redirect,
    input  logic                   i_p4_mem_req,
    input  logic                   i_p4_mem_ready,
    output logic                   o_pc_en,
    output logic                   o_p1p2_en,
    output logic                   o_p2p3_en,
    output logic                   o_p3p4_en,
    output logic                   o_p4p5_en,
    output logic                   o_p1p2_flush,
    output logic                   o_p2p3_flush,
    output logic                   o_p3p4_flush,
    output logic                   o_p4p5_flush,
    output logic [1:0]             o_state,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    localparam int CNT_MAX = (RST_DRAIN_CYCLES > REDIRECT_SHADOW) ? RST_DRAIN_CYCLES : REDIRECT_SHADOW;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(RST_DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHADOW_LOAD = CNT_W'((REDIRECT_SHADOW > 0) ? REDIRECT_SHADOW - 1 : 0);
    localparam pipe_state_e      AFTER_REDIR = (REDIRECT_SHADOW > 0) ? REDIRECT : RUN;

    pipe_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    pipe_strobe_t     stb;
    logic             load_use;
    logic             mem_wait;

    pipe_load_use_det u_load_use_det (
        .i_p2_rs1_addr (i_p2_rs1_addr),
        .i_p2_rs2_addr (i_p2_rs2_addr),
        .i_p2_uses_rs1 (i_p2_uses_rs1),
        .i_p2_uses_rs2 (i_p2_uses_rs2),
        .i_p3_rd_addr  (i_p3_rd_addr),
        .i_p3_mem_read (i_p3_mem_read),
        .o_load_use    (load_use)
    );

    assign mem_wait = i_p4_mem_req && !i_p4_mem_ready;

    always_comb begin
        stb       = STB_RUN;
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            DRAIN: begin
                stb = STB_DRAIN;
                if (cnt == '0) state_nxt = RUN;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            RUN, MEM_WAIT: begin
                // MEM_WAIT holds on ready alone: the access is already committed in P4
                if ((state == RUN) ? mem_wait : !i_p4_mem_ready) begin
                    stb       = STB_MEM_WAIT;
                    state_nxt = MEM_WAIT;
                end else if (i_p3_redirect) begin
                    stb       = STB_REDIRECT;
                    state_nxt = AFTER_REDIR;
                    cnt_nxt   = SHADOW_LOAD;
                end else if (load_use) begin
                    stb       = STB_LOAD_USE;
                    state_nxt = RUN;
                end else if (!i_p1_insn_valid) begin
                    stb       = STB_FETCH_BUB;
                    state_nxt = RUN;
                end else begin
                    state_nxt = RUN;
                end
            end
            REDIRECT: begin
                if (mem_wait) begin
                    stb       = STB_MEM_WAIT;
                    state_nxt = MEM_WAIT;
                end else if (i_p3_redirect) begin
                    stb     = STB_REDIRECT;
                    cnt_nxt = SHADOW_LOAD;
                end else begin
                    stb.pc_en    = i_p1_insn_valid;
                    stb.flush[0] = 1'b1;
                    if (cnt == '0) state_nxt = RUN;
                    else           cnt_nxt   = cnt - CNT_W'(1);
                end
            end
            default: begin
                stb       = STB_DRAIN;
                state_nxt = DRAIN;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= DRAIN;
            cnt         <= DRAIN_LOAD;
            o_stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!stb.pc_en && (state != DRAIN) && (o_stall_cnt != '1))
                o_stall_cnt <= o_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign o_pc_en      = stb.pc_en;
    assign o_p1p2_en    = stb.en[0];
    assign o_p2p3_en    = stb.en[1];
    assign o_p3p4_en    = stb.en[2];
    assign o_p4p5_en    = stb.en[3];
    assign o_p1p2_flush = stb.flush[0];
    assign o_p2p3_flush = stb.flush[1];
    assign o_p3p4_flush = stb.flush[2];
    assign o_p4p5_flush = stb.flush[3];
    assign o_state      = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        p1_insn_valid;
    logic [4:0]  p2_rs1_addr, p2_rs2_addr, p3_rd_addr;
    logic        p2_uses_rs1, p2_uses_rs2, p3_mem_read, p3_redirect;
    logic        p4_mem_req, p4_mem_ready;

    logic        pc_en, p1p2_en, p2p3_en, p3p4_en, p4p5_en;
    logic        p1p2_flush, p2p3_flush, p3p4_flush, p4p5_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    logic        s_pc_en, s_p1p2_en, s_p2p3_en, s_p3p4_en, s_p4p5_en;
    logic        s_p1p2_flush, s_p2p3_flush, s_p3p4_flush, s_p4p5_flush;
    logic [1:0]  s_state;
    logic [1:0]  s_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // {pc_en, en p4p5..p1p2, flush p4p5..p1p2}
    localparam logic [8:0] X_DRAIN = 9'b0_0000_1111;
    localparam logic [8:0] X_RUN   = 9'b1_1111_0000;
    localparam logic [8:0] X_LU    = 9'b0_1110_0010;
    localparam logic [8:0] X_REDIR = 9'b1_1111_0011;
    localparam logic [8:0] X_SHAD  = 9'b1_1111_0001;
    localparam logic [8:0] X_MEMW  = 9'b0_1000_1000;
    localparam logic [8:0] X_FBUB  = 9'b0_1111_0001;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_p1_insn_valid(p1_insn_valid),
        .i_p2_rs1_addr(p2_rs1_addr), .i_p2_rs2_addr(p2_rs2_addr),
        .i_p2_uses_rs1(p2_uses_rs1), .i_p2_uses_rs2(p2_uses_rs2),
        .i_p3_rd_addr(p3_rd_addr), .i_p3_mem_read(p3_mem_read), .i_p3_redirect(p3_redirect),
        .i_p4_mem_req(p4_mem_req), .i_p4_mem_ready(p4_mem_ready),
        .o_pc_en(pc_en), .o_p1p2_en(p1p2_en), .o_p2p3_en(p2p3_en),
        .o_p3p4_en(p3p4_en), .o_p4p5_en(p4p5_en),
        .o_p1p2_flush(p1p2_flush), .o_p2p3_flush(p2p3_flush),
        .o_p3p4_flush(p3p4_flush), .o_p4p5_flush(p4p5_flush),
        .o_state(state), .o_stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.STALL_CNT_W(2)) dut_sat (
        .i_clk(clk), .i_rst(rst), .i_p1_insn_valid(p1_insn_valid),
        .i_p2_rs1_addr(p2_rs1_addr), .i_p2_rs2_addr(p2_rs2_addr),
        .i_p2_uses_rs1(p2_uses_rs1), .i_p2_uses_rs2(p2_uses_rs2),
        .i_p3_rd_addr(p3_rd_addr), .i_p3_mem_read(p3_mem_read), .i_p3_redirect(p3_redirect),
        .i_p4_mem_req(p4_mem_req), .i_p4_mem_ready(p4_mem_ready),
        .o_pc_en(s_pc_en), .o_p1p2_en(s_p1p2_en), .o_p2p3_en(s_p2p3_en),
        .o_p3p4_en(s_p3p4_en), .o_p4p5_en(s_p4p5_en),
        .o_p1p2_flush(s_p1p2_flush), .o_p2p3_flush(s_p2p3_flush),
        .o_p3p4_flush(s_p3p4_flush), .o_p4p5_flush(s_p4p5_flush),
        .o_state(s_state), .o_stall_cnt(s_stall_cnt)
    );

    wire [8:0] stb = {pc_en, p4p5_en, p3p4_en, p2p3_en, p1p2_en,
                      p4p5_flush, p3p4_flush, p2p3_flush, p1p2_flush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        p1_insn_valid = 1'b1;
        p2_rs1_addr = 5'd0; p2_rs2_addr = 5'd0; p3_rd_addr = 5'd0;
        p2_uses_rs1 = 1'b0; p2_uses_rs2 = 1'b0; p3_mem_read = 1'b0; p3_redirect = 1'b0;
        p4_mem_req = 1'b0; p4_mem_ready = 1'b0;
    endtask

    // drive happens right after a negedge; check 2ns later; advance to next negedge
    task automatic cyc_check(input string tag, input logic [8:0] x_stb, input logic [1:0] x_state);
        #2;
        check({tag, "_stb"}, 32'(stb), 32'(x_stb));
        check({tag, "_state"}, 32'(state), 32'(x_state));
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        check("rst_stb", 32'(stb), 32'(X_DRAIN));
        check("rst_state", 32'(state), 32'd0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc_check("drain0", X_DRAIN, 2'd0);
        cyc_check("drain1", X_DRAIN, 2'd0);
        cyc_check("run0", X_RUN, 2'd1);
        check("drain_stall", 32'(stall_cnt), 32'd0);

        // load-use via rs1
        p3_mem_read = 1'b1; p3_rd_addr = 5'd5; p2_uses_rs1 = 1'b1; p2_rs1_addr = 5'd5;
        cyc_check("lu_rs1", X_LU, 2'd1);
        idle();
        cyc_check("lu_clear", X_RUN, 2'd1);
        check("lu_stall", 32'(stall_cnt), 32'd1);

        // load to x0 is no hazard
        p3_mem_read = 1'b1; p3_rd_addr = 5'd0; p2_uses_rs1 = 1'b1; p2_rs1_addr = 5'd0;
        cyc_check("lu_x0", X_RUN, 2'd1);
        // matching rs2 but unused, then used
        idle();
        p3_mem_read = 1'b1; p3_rd_addr = 5'd7; p2_rs2_addr = 5'd7;
        cyc_check("lu_rs2_unused", X_RUN, 2'd1);
        p2_uses_rs2 = 1'b1;
        cyc_check("lu_rs2", X_LU, 2'd1);
        idle();
        check("lu2_stall", 32'(stall_cnt), 32'd2);

        // fetch bubble
        p1_insn_valid = 1'b0;
        cyc_check("fbub", X_FBUB, 2'd1);
        idle();
        check("fbub_stall", 32'(stall_cnt), 32'd3);

        // redirect with one shadow cycle
        p3_redirect = 1'b1;
        cyc_check("redir", X_REDIR, 2'd1);
        idle();
        cyc_check("shadow", X_SHAD, 2'd3);
        cyc_check("post_redir", X_RUN, 2'd1);
        check("redir_stall", 32'(stall_cnt), 32'd3);

        // three wait states then release
        p4_mem_req = 1'b1; p4_mem_ready = 1'b0;
        cyc_check("memw0", X_MEMW, 2'd1);
        cyc_check("memw1", X_MEMW, 2'd2);
        cyc_check("memw2", X_MEMW, 2'd2);
        p4_mem_ready = 1'b1;
        cyc_check("mem_rel", X_RUN, 2'd2);
        idle();
        cyc_check("mem_after", X_RUN, 2'd1);
        check("mem_stall", 32'(stall_cnt), 32'd6);

        // mem wait dominates redirect and load-use; redirect wins at release
        p4_mem_req = 1'b1; p4_mem_ready = 1'b0; p3_redirect = 1'b1;
        p3_mem_read = 1'b1; p3_rd_addr = 5'd9; p2_uses_rs1 = 1'b1; p2_rs1_addr = 5'd9;
        cyc_check("combo0", X_MEMW, 2'd1);
        cyc_check("combo1", X_MEMW, 2'd2);
        p4_mem_ready = 1'b1;
        cyc_check("combo_rel", X_REDIR, 2'd2);
        idle();
        cyc_check("combo_shadow", X_SHAD, 2'd3);
        cyc_check("combo_run", X_RUN, 2'd1);
        check("combo_stall", 32'(stall_cnt), 32'd8);

        // asynchronous reset in MEM_WAIT
        p4_mem_req = 1'b1; p4_mem_ready = 1'b0;
        cyc_check("pre_rst", X_MEMW, 2'd1);
        check("pre_rst_state", 32'(state), 32'd2);
        rst = 1'b1;
        #1;
        check("arst_stb", 32'(stb), 32'(X_DRAIN));
        check("arst_state", 32'(state), 32'd0);
        check("arst_stall", 32'(stall_cnt), 32'd0);
        check("arst_sat_stall", 32'(s_stall_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        cyc_check("rdrain0", X_DRAIN, 2'd0);
        cyc_check("rdrain1", X_DRAIN, 2'd0);

        // five stall cycles: narrow counter saturates at 3
        p4_mem_req = 1'b1; p4_mem_ready = 1'b0;
        cyc_check("sat0", X_MEMW, 2'd1);
        for (int i = 1; i < 5; i++) cyc_check("satn", X_MEMW, 2'd2);
        p4_mem_ready = 1'b1;
        cyc_check("sat_rel", X_RUN, 2'd2);
        idle();
        check("sat_wide", 32'(stall_cnt), 32'd5);
        check("sat_narrow", 32'(s_stall_cnt), 32'd3);
        p4_mem_req = 1'b1; p4_mem_ready = 1'b0;
        cyc_check("sat_more", X_MEMW, 2'd1);
        idle();
        check("sat_hold", 32'(s_stall_cnt), 32'd3);
        check("sat_wide2", 32'(stall_cnt), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central sequencing controller for the 5-stage pipeline (P1 fetch .. P5 writeback). It produces per-register enable and flush strobes for the PC and the p1p2, p2p3, p3p4 and p4p5 pipeline registers. It resolves load-use hazards, branch/jump redirects, data-memory wait states, fetch bubbles and the post-reset drain. Each pipeline register loads its bubble value (insn = 32'h00000013 NOP, ctrl = '0) when its flush is 1; flush overrides enable.

Parameters:
RST_DRAIN_CYCLES, 2, cycles after reset release during which all stages are flushed and the PC is held (>=1).
REDIRECT_SHADOW, 1, extra cycles p1p2 is flushed after a redirect, covering the synchronous imem fetch in flight (>=0).
STALL_CNT_W, 16, width of the saturating stall performance counter.

Ports:
i_clk  in  1  core clock
i_rst  in  1  asynchronous reset, active-high
i_p1_insn_valid  in  1  fetched instruction valid this cycle
i_p2_rs1_addr  in  5  decode-stage rs1 index
i_p2_rs2_addr  in  5  decode-stage rs2 index
i_p2_uses_rs1  in  1  decode instruction reads rs1
i_p2_uses_rs2  in  1  decode instruction reads rs2
i_p3_rd_addr  in  5  execute-stage destination index
i_p3_mem_read  in  1  execute-stage instruction is a load
i_p3_redirect  in  1  taken branch/jump resolved in P3
i_p4_mem_req  in  1  P4 data-memory access active
i_p4_mem_ready  in  1  data memory completes access this cycle
o_pc_en  out  1  PC register update enable
o_p1p2_en, o_p2p3_en, o_p3p4_en, o_p4p5_en  out  1 each  register enables
o_p1p2_flush, o_p2p3_flush, o_p3p4_flush, o_p4p5_flush  out  1 each  bubble insert
o_state  out  2  current FSM state (debug)
o_stall_cnt  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- FSM states: DRAIN=0, RUN=1, MEM_WAIT=2, REDIRECT=3. A single down-counter cnt (width covers max(RST_DRAIN_CYCLES, REDIRECT_SHADOW)) is shared between DRAIN and REDIRECT.
- Reset (i_rst=1, asynchronous, at any time including mid-stall): state=DRAIN, cnt=RST_DRAIN_CYCLES-1, o_stall_cnt=0. Outputs while in reset: all en=0, all flush=1, o_pc_en=0, o_state=0.
- All strobes are combinational from the registered state plus the current inputs. Everything else is registered. Hazard action takes effect at the same clock edge as detection, so latency is 0 cycles.
- DRAIN: pc_en=0, all flush=1. cnt decrements each cycle; move to RUN when cnt==0.
- RUN, with priority highest first:
  1. mem_wait = i_p4_mem_req & ~i_p4_mem_ready. pc, p1p2, p2p3 and p3p4 en=0. p4p5_flush=1. Next state=MEM_WAIT.
  2. i_p3_redirect: pc_en=1 (target loads), p1p2_flush=1, p2p3_flush=1, p3p4/p4p5 en=1. If REDIRECT_SHADOW>0: next=REDIRECT, cnt=REDIRECT_SHADOW-1.
  3. load_use = i_p3_mem_read & (i_p3_rd_addr!=0) & ((uses_rs1 & rs1==rd) | (uses_rs2 & rs2==rd)). pc_en=0, p1p2_en=0, p2p3_flush=1, p3p4/p4p5 en=1. Stays in RUN; the condition self-clears after one cycle.
  4. ~i_p1_insn_valid: pc_en=0, p1p2_flush=1, all other en=1.
  5. Otherwise all en=1 and all flush=0.
- MEM_WAIT: same strobes as RUN item 1 while ~i_p4_mem_ready. On the cycle i_p4_mem_ready=1, all en=1, evaluate RUN items 2-4 normally, and set next=RUN (or REDIRECT if item 2 fires). A redirect pending in P3 is held frozen and acted on at release, never lost.
- REDIRECT: p1p2_flush=1 and pc_en=i_p1_insn_valid. Other stages run normally, except that mem_wait still takes priority (goes to MEM_WAIT; the shadow is abandoned because the imem output stays held). A new i_p3_redirect reloads cnt. Move to RUN when cnt==0.
- A load-use hazard is never evaluated in DRAIN or REDIRECT, because P2 holds a bubble there.
- o_stall_cnt increments by 1 in any cycle with o_pc_en=0 and state!=DRAIN. It saturates at all-ones.

Decomposition:
- cpu_types.vh gains:
  - pipe_state_e (2-bit enum DRAIN/RUN/MEM_WAIT/REDIRECT)
  - pipe_strobe_t packed struct {pc_en, en[4], flush[4]}
  - localparam NOP_INSN = 32'h00000013, which the existing pipeline registers reuse as their bubble value.
- Sub-module pipe_load_use_det: purely combinational, computes load_use from the P2/P3 fields. It is reused later by the forwarding unit.

Test Plan:
- Reset release with RST_DRAIN_CYCLES=2 -> 2 cycles of all flush=1 and pc_en=0, then state=RUN with all en=1; o_stall_cnt stays 0.
- P3 lw x5 (rd=5, mem_read=1) with P2 add x6,x5,x1 (uses_rs1, rs1=5) -> exactly 1 cycle of pc_en=0, p1p2_en=0, p2p3_flush=1; o_stall_cnt=1. Repeat with rd=0 -> no stall.
- i_p3_redirect=1 for 1 cycle -> that cycle p1p2_flush=p2p3_flush=1 and pc_en=1; next cycle state=REDIRECT with p1p2_flush=1; then RUN.
- i_p4_mem_req=1, ready low for 3 cycles -> 3 cycles of p4p5_flush=1 and p3p4_en=0, state=MEM_WAIT; ready=1 -> all en=1 and state=RUN; o_stall_cnt=3.
- mem_wait plus redirect plus load-use at once -> MEM_WAIT strobes only. At release with redirect still high -> redirect strobes, not load-use.
- Assert i_rst mid-MEM_WAIT -> outputs go to reset values asynchronously (before the next edge) and o_stall_cnt=0. Force the counter to all-ones -> it stays saturated.
